// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: FSM states and frame constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERR
  } state_t;

  // Default instruction-memory depth in 32-bit words.
  localparam int IMEM_WORDS_DEFAULT = 64;

  // Frame header is LEN_LO then LEN_HI.
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words.
// Latency: word_vld/word_dat registered, one cycle after the 4th byte is taken.
// Backpressure: none; the caller only presents bytes it has already accepted.
// Ports: clk/rst; flush clears a partial word; byte_vld/byte_dat accepted byte;
//        last_byte high when the next byte completes a word; word_vld/word_dat packed word.
module loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        last_byte,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  // Holds the first three bytes of the word; newest byte enters at the top,
  // so after three shifts the first byte sits in [7:0].
  logic [23:0] shreg;
  logic [1:0]  bcnt;

  assign last_byte = (bcnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bcnt     <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (flush) begin
        bcnt <= '0;
      end else if (byte_vld) begin
        bcnt  <= bcnt + 2'd1;
        shreg <= {byte_dat, shreg[23:8]};
        if (last_byte) begin
          word_vld <= 1'b1;
          word_dat <= {byte_dat, shreg};
        end
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed, XOR-checked byte frame and writes it into instruction memory.
// Latency: imem write one cycle after the 4th byte of each word; status follows the state register.
// Backpressure: in_ready high while loading, low in RUN/ERR; reload aborts and discards a same-cycle byte.
// Ports: clk/rst; in_valid/in_data/in_ready byte stream; reload restart request;
//        imem_we/imem_waddr/imem_wdata memory write; cpu_rst/done/error status.
module boot_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int AW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          error
);

  state_t        state, nstate;
  logic [15:0]   len;
  logic [15:0]   last_idx;
  logic [15:0]   hdr_n;
  logic [AW-1:0] wcnt;
  logic [7:0]    csum;
  logic          acc;
  logic          pay_acc;
  logic          last_byte;
  logic          last_word;

  assign in_ready  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign acc       = in_valid && in_ready;
  // A reload in the same cycle wins, so the byte never reaches the packer.
  assign pay_acc   = acc && (state == ST_PAYLOAD) && !reload;
  assign hdr_n     = {in_data, len[7:0]};
  assign last_idx  = len - 16'd1;
  assign last_word = ({{(16-AW){1'b0}}, wcnt} == last_idx);

  loader_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .flush     (reload || (state != ST_PAYLOAD)),
    .byte_vld  (pay_acc),
    .byte_dat  (in_data),
    .last_byte (last_byte),
    .word_vld  (imem_we),
    .word_dat  (imem_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LEN_LO;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate  = state;
    cpu_rst = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (state)
      ST_LEN_LO: begin
        if (acc) nstate = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (acc) begin
          if ({16'd0, hdr_n} > 32'(IMEM_WORDS)) nstate = ST_ERR;
          else if (hdr_n == 16'd0)              nstate = ST_CHECK;
          else                                   nstate = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (acc && last_byte && last_word) nstate = ST_CHECK;
      end
      ST_CHECK: begin
        if (acc) nstate = (csum == in_data) ? ST_RUN : ST_ERR;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: nstate = ST_LEN_LO;
    endcase
    if (reload) nstate = ST_LEN_LO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= '0;
      wcnt       <= '0;
      csum       <= '0;
      imem_waddr <= '0;
    end else begin
      if (acc && (state == ST_LEN_LO)) len[7:0]  <= in_data;
      if (acc && (state == ST_LEN_HI)) len[15:8] <= in_data;

      // Word index restarts for every frame; the last word exits PAYLOAD,
      // so the increment past IMEM_WORDS-1 is never observed.
      if ((state != ST_PAYLOAD) || reload) begin
        wcnt <= '0;
      end else if (pay_acc && last_byte) begin
        wcnt       <= wcnt + 1'b1;
        imem_waddr <= wcnt;
      end

      if (state == ST_LEN_LO) csum <= '0;
      else if (pay_acc)       csum <= csum ^ in_data;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: scoreboard of expected imem writes plus status checks.
// Latency: n/a.
// Backpressure: bytes are held on in_valid until in_ready, with bounded waits.
module tb_boot_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int base;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words[0:63];
  bit             rand_gap = 1'b0;

  boot_loader #(.IMEM_WORDS(64), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {26'd0, imem_waddr, imem_wdata}, 64'hDEAD);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("we_addr", 64'(imem_waddr), 64'(e[AW+31:32]));
        chk("we_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    logic [AW-1:0] a;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[w][8*k +: 8];
        cs = cs ^ b;
        if (k == 3) begin
          a = AW'(w);
          exp_q.push_back({a, words[w]});
        end
        send_byte(b);
      end
    end
    send_byte(bad ? ~cs : cs);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_async_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_waddr", 64'(imem_waddr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    rst = 1'b0;

    // Two-word frame, good checksum
    base = nwr;
    words[0] = 32'h00500093;
    words[1] = 32'h00A00113;
    send_frame(2, 1'b0);
    settle();
    chk("n2_writes", 64'(nwr - base), 64'd2);
    chk("n2_done", 64'(done), 64'd1);
    chk("n2_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("n2_ready", 64'(in_ready), 64'd0);
    chk("n2_error", 64'(error), 64'd0);
    do_reload();
    chk("rl_ready", 64'(in_ready), 64'd1);
    chk("rl_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rl_done", 64'(done), 64'd0);

    // Corrupted checksum
    base = nwr;
    words[0] = 32'hCAFEF00D;
    send_frame(1, 1'b1);
    settle();
    chk("bad_writes", 64'(nwr - base), 64'd1);
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("bad_ready", 64'(in_ready), 64'd0);
    chk("bad_done", 64'(done), 64'd0);
    do_reload();
    chk("bad_rl_error", 64'(error), 64'd0);
    chk("bad_rl_ready", 64'(in_ready), 64'd1);

    // Oversize header
    base = nwr;
    send_byte(8'd65);
    send_byte(8'd0);
    settle();
    chk("n65_error", 64'(error), 64'd1);
    chk("n65_writes", 64'(nwr - base), 64'd0);
    do_reload();

    // Empty frame
    send_frame(0, 1'b0);
    settle();
    chk("n0_done", 64'(done), 64'd1);
    chk("n0_writes", 64'(nwr - base), 64'd0);
    do_reload();

    // Full-depth frame with random valid gaps
    base = nwr;
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    rand_gap = 1'b1;
    send_frame(64, 1'b0);
    rand_gap = 1'b0;
    settle();
    chk("n64_writes", 64'(nwr - base), 64'd64);
    chk("n64_done", 64'(done), 64'd1);
    chk("n64_error", 64'(error), 64'd0);
    do_reload();

    // Asynchronous reset mid-payload
    send_byte(8'd1);
    send_byte(8'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_we", 64'(imem_we), 64'd0);
    chk("mid_rst_waddr", 64'(imem_waddr), 64'd0);
    chk("mid_rst_wdata", 64'(imem_wdata), 64'd0);
    chk("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_error", 64'(error), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    base = nwr;
    words[0] = 32'h12345678;
    words[1] = 32'h9ABCDEF0;
    send_frame(2, 1'b0);
    settle();
    chk("post_rst_writes", 64'(nwr - base), 64'd2);
    chk("post_rst_done", 64'(done), 64'd1);
    do_reload();

    // Reload coincident with the 4th payload byte
    base = nwr;
    send_byte(8'd1);
    send_byte(8'd0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA4;
    reload   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reload   = 1'b0;
    @(negedge clk);
    chk("abort_we", 64'(imem_we), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    settle();
    chk("abort_writes", 64'(nwr - base), 64'd0);
    words[0] = 32'h0BADBEEF;
    send_frame(1, 1'b0);
    settle();
    chk("after_abort_writes", 64'(nwr - base), 64'd1);
    chk("after_abort_done", 64'(done), 64'd1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
